// File: rtl/serv_rf_ram_bridge.sv
// serv_rf_ram_bridge
//   Converts the bit-serial register-file ports (two read ports, two write
//   ports, 1-bit data) into word accesses on a W-bit RAM with one read port
//   and one write port. Both read streams share the RAM read port and both
//   write streams share the RAM write port. Each request moves one 32-bit
//   register, LSB first.
//
// Ports
//   i_clk, i_rst_n      clock (rising edge), asynchronous active-low reset
//   i_rreq, o_ready     transfer request (IDLE only) / one-cycle start pulse
//   i_rreg0, i_rreg1    read register indices, latched on accepted request
//   o_rdata0, o_rdata1  serial read data, LSB first, 0 outside RUN
//   i_wreg0/1, i_wen0/1 write register and enable, sampled on each word's last bit
//   i_wdata0, i_wdata1  serial write data, LSB first
//   o_raddr, o_ren      RAM read address/enable (combinational), data next cycle
//   i_rdata             RAM read data
//   o_waddr, o_wdata,   RAM write address/data/enable (registered)
//   o_wen
module serv_rf_ram_bridge #(
  parameter int W        = 4,
  parameter int WITH_CSR = 1,
  parameter int AW       = 5 + WITH_CSR + $clog2(32 / W)
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_rreq,
  output logic                  o_ready,
  input  logic [4+WITH_CSR:0]   i_rreg0,
  input  logic [4+WITH_CSR:0]   i_rreg1,
  output logic                  o_rdata0,
  output logic                  o_rdata1,
  input  logic [4+WITH_CSR:0]   i_wreg0,
  input  logic [4+WITH_CSR:0]   i_wreg1,
  input  logic                  i_wen0,
  input  logic                  i_wen1,
  input  logic                  i_wdata0,
  input  logic                  i_wdata1,
  output logic [AW-1:0]         o_raddr,
  output logic                  o_ren,
  input  logic [W-1:0]          i_rdata,
  output logic [AW-1:0]         o_waddr,
  output logic [W-1:0]          o_wdata,
  output logic                  o_wen
);

  localparam int RW    = 5 + WITH_CSR;
  localparam int WORDS = 32 / W;
  localparam int LW    = $clog2(W);
  localparam int WB    = $clog2(WORDS);

  localparam logic [LW-1:0] OFF_PRE  = LW'(W - 2);
  localparam logic [LW-1:0] OFF_LAST = LW'(W - 1);
  localparam logic [4:0]    WD_LAST  = 5'(WORDS - 1);

  typedef enum logic [2:0] {
    IDLE,
    P0,
    P1,
    RUN,
    F0,
    F1
  } state_t;

  state_t state;
  state_t state_next;

  logic [4:0]    cnt;
  logic [LW-1:0] off;
  logic [4:0]    wd;
  logic          more_words;

  logic [RW-1:0] rreg0_q;
  logic [RW-1:0] rreg1_q;
  logic [W-1:0]  rs1_sr;
  logic [W-1:0]  rs2_sr;

  logic [W-1:0]  wsr0;
  logic [W-1:0]  wsr1;
  logic          pend1;
  logic          wen1_q;
  logic [RW-1:0] wreg1_q;
  logic [4:0]    wd_q;
  logic [W-1:0]  word1_q;

  // RAM address is {register, word}; with W=32 the word field is empty and
  // the word index is always zero, so OR-ing it in is harmless.
  function automatic logic [AW-1:0] ram_addr(input logic [RW-1:0] r, input logic [4:0] w);
    ram_addr = (AW'(r) << WB) | AW'(w);
  endfunction

  assign off        = cnt[LW-1:0];
  assign wd         = cnt >> LW;
  assign more_words = (wd < WD_LAST);

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic and RAM read-port control. The two prime cycles fetch
  // word 0 of each register; during RUN the next word of port 0 is fetched
  // two bits before a word boundary and port 1 one bit before, so each lands
  // exactly when its shift register needs it. No prefetch past the last word.
  always_comb begin
    state_next = state;
    o_ren      = 1'b0;
    o_raddr    = '0;
    o_ready    = 1'b0;
    case (state)
      IDLE: begin
        if (i_rreq) begin
          state_next = P0;
        end
      end
      P0: begin
        o_ren      = 1'b1;
        o_raddr    = ram_addr(rreg0_q, 5'd0);
        state_next = P1;
      end
      P1: begin
        o_ren      = 1'b1;
        o_raddr    = ram_addr(rreg1_q, 5'd0);
        o_ready    = 1'b1;
        state_next = RUN;
      end
      RUN: begin
        if (more_words && (off == OFF_PRE)) begin
          o_ren   = 1'b1;
          o_raddr = ram_addr(rreg0_q, wd + 5'd1);
        end else if (more_words && (off == OFF_LAST)) begin
          o_ren   = 1'b1;
          o_raddr = ram_addr(rreg1_q, wd + 5'd1);
        end
        if (cnt == 5'd31) begin
          state_next = F0;
        end
      end
      F0: begin
        state_next = F1;
      end
      F1: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Port 1 data is taken straight from the RAM on the first bit of each word
  // because its word arrives in that very cycle; the remaining bits come from
  // the shift register loaded with the word minus that bit.
  assign o_rdata0 = (state == RUN) ? rs1_sr[0] : 1'b0;
  assign o_rdata1 = (state == RUN) ? ((off == '0) ? i_rdata[0] : rs2_sr[0]) : 1'b0;

  // Bit counter, latched read registers and the two read shift registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt     <= '0;
      rreg0_q <= '0;
      rreg1_q <= '0;
      rs1_sr  <= '0;
      rs2_sr  <= '0;
    end else begin
      if ((state == IDLE) && i_rreq) begin
        rreg0_q <= i_rreg0;
        rreg1_q <= i_rreg1;
      end
      if (state == RUN) begin
        cnt <= cnt + 5'd1;
      end else begin
        cnt <= '0;
      end
      if (state == P1) begin
        rs1_sr <= i_rdata;
      end else if (state == RUN) begin
        if (off == OFF_LAST) begin
          rs1_sr <= i_rdata;
        end else begin
          rs1_sr <= rs1_sr >> 1;
        end
      end
      if (state == RUN) begin
        if (off == '0) begin
          rs2_sr <= i_rdata >> 1;
        end else begin
          rs2_sr <= rs2_sr >> 1;
        end
      end
    end
  end

  // Write path. Serial bits enter at the MSB so a word is complete on its
  // last bit. That cycle issues the port-0 write and parks everything for
  // port 1, which goes out one cycle later so it lands last and wins on an
  // address collision. Reset drops any partial word and any parked write.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wsr0    <= '0;
      wsr1    <= '0;
      pend1   <= 1'b0;
      wen1_q  <= 1'b0;
      wreg1_q <= '0;
      wd_q    <= '0;
      word1_q <= '0;
      o_wen   <= 1'b0;
      o_waddr <= '0;
      o_wdata <= '0;
    end else begin
      o_wen <= 1'b0;
      if (state == RUN) begin
        wsr0 <= {i_wdata0, wsr0[W-1:1]};
        wsr1 <= {i_wdata1, wsr1[W-1:1]};
      end
      if (pend1) begin
        pend1   <= 1'b0;
        o_wen   <= wen1_q;
        o_waddr <= ram_addr(wreg1_q, wd_q);
        o_wdata <= word1_q;
      end
      if ((state == RUN) && (off == OFF_LAST)) begin
        o_wen   <= i_wen0;
        o_waddr <= ram_addr(i_wreg0, wd);
        o_wdata <= {i_wdata0, wsr0[W-1:1]};
        pend1   <= 1'b1;
        wen1_q  <= i_wen1;
        wreg1_q <= i_wreg1;
        wd_q    <= wd;
        word1_q <= {i_wdata1, wsr1[W-1:1]};
      end
    end
  end

endmodule

// File: tb/tb_serv_rf_ram_bridge.sv
// tb_serv_rf_ram_bridge
//   Drives serv_rf_ram_bridge (W=4, WITH_CSR=1) against a 1-cycle-latency
//   RAM and a register-level reference model: reads return the value the
//   register held when the transfer started, writes replace whole nibbles
//   with port 1 applied after port 0.
module tb_serv_rf_ram_bridge;

  localparam int W        = 4;
  localparam int WITH_CSR = 1;
  localparam int AW       = 9;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_rreq;
  logic          o_ready;
  logic [5:0]    i_rreg0;
  logic [5:0]    i_rreg1;
  logic          o_rdata0;
  logic          o_rdata1;
  logic [5:0]    i_wreg0;
  logic [5:0]    i_wreg1;
  logic          i_wen0;
  logic          i_wen1;
  logic          i_wdata0;
  logic          i_wdata1;
  logic [AW-1:0] o_raddr;
  logic          o_ren;
  logic [W-1:0]  ram_rdata;
  logic [AW-1:0] o_waddr;
  logic [W-1:0]  o_wdata;
  logic          o_wen;

  logic [3:0]    mem [512];
  logic          pl_en;
  logic [8:0]    pl_addr;
  logic [3:0]    pl_data;

  logic [31:0]   ref_rf [64];
  int            total;
  int            bad;

  serv_rf_ram_bridge #(.W(W), .WITH_CSR(WITH_CSR), .AW(AW)) dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_rreq   (i_rreq),
    .o_ready  (o_ready),
    .i_rreg0  (i_rreg0),
    .i_rreg1  (i_rreg1),
    .o_rdata0 (o_rdata0),
    .o_rdata1 (o_rdata1),
    .i_wreg0  (i_wreg0),
    .i_wreg1  (i_wreg1),
    .i_wen0   (i_wen0),
    .i_wen1   (i_wen1),
    .i_wdata0 (i_wdata0),
    .i_wdata1 (i_wdata1),
    .o_raddr  (o_raddr),
    .o_ren    (o_ren),
    .i_rdata  (ram_rdata),
    .o_waddr  (o_waddr),
    .o_wdata  (o_wdata),
    .o_wen    (o_wen)
  );

  always #5 clk = ~clk;

  // RAM with registered read; the bench preload port has priority.
  always @(posedge clk) begin
    if (pl_en) begin
      mem[pl_addr] <= pl_data;
    end else if (o_wen) begin
      mem[o_waddr] <= o_wdata;
    end
    if (o_ren) begin
      ram_rdata <= mem[o_raddr];
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic preloadReg(input logic [5:0] r, input logic [31:0] v);
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      pl_en   = 1'b1;
      pl_addr = {r, 3'(j)};
      pl_data = v[4*j +: 4];
    end
    @(negedge clk);
    pl_en     = 1'b0;
    ref_rf[r] = v;
  endtask

  task automatic checkReg(input logic [5:0] r);
    logic [31:0] v;
    for (int j = 0; j < 8; j++) begin
      v[4*j +: 4] = mem[{r, 3'(j)}];
    end
    checkOutput("ram_reg", v, ref_rf[r]);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_ready"}, 32'(o_ready), 32'd0);
    checkOutput({tag, "_ren"},   32'(o_ren),   32'd0);
    checkOutput({tag, "_raddr"}, 32'(o_raddr), 32'd0);
    checkOutput({tag, "_rd0"},   32'(o_rdata0), 32'd0);
    checkOutput({tag, "_rd1"},   32'(o_rdata1), 32'd0);
    checkOutput({tag, "_wen"},   32'(o_wen),   32'd0);
    checkOutput({tag, "_waddr"}, 32'(o_waddr), 32'd0);
    checkOutput({tag, "_wdata"}, 32'(o_wdata), 32'd0);
  endtask

  // One request; k counts cycles from the request cycle t. Outputs are
  // checked at the falling edge, then the cycle's inputs are driven.
  // rst_at >= 0 drops reset during the RUN cycle carrying that bit index.
  task automatic applyStimulus(input logic [5:0] r0, input logic [5:0] r1,
                               input logic [5:0] w0, input logic [5:0] w1,
                               input logic e0, input logic e1,
                               input logic [31:0] d0, input logic [31:0] d1,
                               input logic hold_req, input int rst_at);
    logic [31:0] exp0;
    logic [31:0] exp1;
    int          j;
    exp0 = ref_rf[r0];
    exp1 = ref_rf[r1];
    for (int k = 0; k < 37; k++) begin
      @(negedge clk);
      if (k == 0) begin
        checkOutput("idle_ren", 32'(o_ren), 32'd0);
      end
      if (k == 1) begin
        checkOutput("p0_ren",   32'(o_ren),   32'd1);
        checkOutput("p0_raddr", 32'(o_raddr), 32'({r0, 3'd0}));
      end
      if (k == 2) begin
        checkOutput("ready",    32'(o_ready), 32'd1);
        checkOutput("p1_ren",   32'(o_ren),   32'd1);
        checkOutput("p1_raddr", 32'(o_raddr), 32'({r1, 3'd0}));
      end else begin
        checkOutput("ready_low", 32'(o_ready), 32'd0);
      end
      if (k >= 3 && k <= 34) begin
        checkOutput("rdata0", 32'(o_rdata0), 32'(exp0[k-3]));
        checkOutput("rdata1", 32'(o_rdata1), 32'(exp1[k-3]));
      end else begin
        checkOutput("rdata0_idle", 32'(o_rdata0), 32'd0);
        checkOutput("rdata1_idle", 32'(o_rdata1), 32'd0);
      end
      if (k >= 7 && ((k - 7) % 4) == 0) begin
        j = (k - 7) / 4;
        checkOutput("wen0", 32'(o_wen), 32'(e0));
        if (e0) begin
          checkOutput("waddr0", 32'(o_waddr), 32'({w0, 3'(j)}));
          checkOutput("wdata0", 32'(o_wdata), 32'(d0[4*j +: 4]));
        end
      end else if (k >= 8 && ((k - 8) % 4) == 0) begin
        j = (k - 8) / 4;
        checkOutput("wen1", 32'(o_wen), 32'(e1));
        if (e1) begin
          checkOutput("waddr1", 32'(o_waddr), 32'({w1, 3'(j)}));
          checkOutput("wdata1", 32'(o_wdata), 32'(d1[4*j +: 4]));
        end
      end else begin
        checkOutput("wen_gap", 32'(o_wen), 32'd0);
      end

      i_rreq  = (k == 0) ? 1'b1 : hold_req;
      i_rreg0 = (k == 0) ? r0 : 6'($urandom);
      i_rreg1 = (k == 0) ? r1 : 6'($urandom);
      if (k >= 3 && k <= 34) begin
        i_wdata0 = d0[k-3];
        i_wdata1 = d1[k-3];
        i_wreg0  = w0;
        i_wreg1  = w1;
        i_wen0   = e0;
        i_wen1   = e1;
      end else begin
        i_wdata0 = 1'($urandom);
        i_wdata1 = 1'($urandom);
        i_wreg0  = 6'($urandom);
        i_wreg1  = 6'($urandom);
        i_wen0   = 1'($urandom);
        i_wen1   = 1'($urandom);
      end

      if (rst_at >= 0 && k == rst_at + 3) begin
        rst_n = 1'b0;
        #1;
        checkAllZero("rst_mid");
        i_rreq = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        // Port 0 of word n lands at the edge after bit 4n+3, port 1 one edge
        // later; reset during bit c kills every write not landed before it.
        for (int n = 0; n < 8; n++) begin
          if (e0 && (4*n + 4 <= rst_at - 1)) ref_rf[w0][4*n +: 4] = d0[4*n +: 4];
          if (e1 && (4*n + 5 <= rst_at - 1)) ref_rf[w1][4*n +: 4] = d1[4*n +: 4];
        end
        return;
      end
    end
    for (int n = 0; n < 8; n++) begin
      if (e0) ref_rf[w0][4*n +: 4] = d0[4*n +: 4];
      if (e1) ref_rf[w1][4*n +: 4] = d1[4*n +: 4];
    end
    if (!hold_req) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [5:0]  r0, r1, w0, w1;
    logic        e0, e1;
    logic [31:0] d0, d1;
    total    = 0;
    bad      = 0;
    rst_n    = 1'b0;
    i_rreq   = 1'b0;
    i_rreg0  = '0;
    i_rreg1  = '0;
    i_wreg0  = '0;
    i_wreg1  = '0;
    i_wen0   = 1'b0;
    i_wen1   = 1'b0;
    i_wdata0 = 1'b0;
    i_wdata1 = 1'b0;
    pl_en    = 1'b0;
    pl_addr  = '0;
    pl_data  = '0;

    $display("[TB] preloading RAM");
    for (int a = 0; a < 512; a++) begin
      @(negedge clk);
      pl_en   = 1'b1;
      pl_addr = 9'(a);
      pl_data = 4'($urandom);
      ref_rf[6'(a >> 3)][(a % 8) * 4 +: 4] = pl_data;
    end
    @(negedge clk);
    pl_en = 1'b0;
    preloadReg(6'd5, 32'hDEADBEEF);
    preloadReg(6'd7, 32'h12345678);

    checkAllZero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] read x5/x7");
    applyStimulus(6'd5, 6'd7, 6'($urandom), 6'($urandom), 1'b0, 1'b0,
                  $urandom, $urandom, 1'b0, -1);

    $display("[TB] stream write to x9");
    applyStimulus(6'($urandom), 6'($urandom), 6'd9, 6'($urandom), 1'b1, 1'b0,
                  32'hA5A5F00F, $urandom, 1'b0, -1);
    checkReg(6'd9);

    $display("[TB] CSR register on both ports");
    applyStimulus(6'h21, 6'h21, 6'($urandom), 6'($urandom), 1'b0, 1'b0,
                  $urandom, $urandom, 1'b0, -1);

    $display("[TB] same-address writes");
    applyStimulus(6'd9, 6'd5, 6'd3, 6'd3, 1'b1, 1'b1,
                  32'h0, 32'hFFFFFFFF, 1'b0, -1);
    checkReg(6'd3);
    applyStimulus(6'd3, 6'd9, 6'($urandom), 6'($urandom), 1'b0, 1'b0,
                  $urandom, $urandom, 1'b0, -1);

    $display("[TB] request held high");
    for (int n = 0; n < 4; n++) begin
      applyStimulus(6'($urandom), 6'($urandom), 6'($urandom), 6'($urandom),
                    1'($urandom), 1'($urandom), $urandom, $urandom,
                    (n < 3) ? 1'b1 : 1'b0, -1);
    end

    $display("[TB] reset mid-transfer");
    w0 = 6'd12;
    applyStimulus(6'd7, 6'd5, w0, 6'($urandom), 1'b1, 1'b0,
                  $urandom, $urandom, 1'b0, 13);
    checkReg(w0);
    applyStimulus(w0, 6'd7, 6'($urandom), 6'($urandom), 1'b0, 1'b0,
                  $urandom, $urandom, 1'b0, -1);

    $display("[TB] random transfers");
    for (int n = 0; n < 6; n++) begin
      r0 = 6'($urandom);
      r1 = 6'($urandom);
      w0 = 6'($urandom);
      w1 = 6'($urandom);
      e0 = 1'($urandom);
      e1 = 1'($urandom);
      d0 = $urandom;
      d1 = $urandom;
      applyStimulus(r0, r1, w0, w1, e0, e1, d0, d1, 1'b0, -1);
      checkReg(w0);
      checkReg(w1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
